decrypt_single_round: RTL and testbench

Inverse of one AES encrypt round, with a 2-stage registered pipeline and valid/ready flow control.
- Normal round: AddRoundKey -> InvMixColumns -> InvShiftRows -> InvSubBytes.
- With last_round high, InvMixColumns is bypassed, which undoes the final encrypt round.
- Used as the per-round building block of the AES decrypt datapath. Chained in reverse round-key order, it exactly undoes encryptSingleRound given the same key.

---
 rtl/decrypt_single_round.sv | 140 ++++++++++++++
 tb/tb_decrypt_single_round.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_single_round.sv
// decrypt_single_round: inverse of one AES encrypt round (AddRoundKey -> InvMixColumns ->
// InvShiftRows -> InvSubBytes), InvMixColumns skipped when last_round is set.
// Latency: 2 cycles (s1 register, output register); one beat per cycle sustained.
// Backpressure: stall = round_valid_out & ~round_ready_in freezes both stages; round_ready_out = ~stall.
// Ports: clk/rst (sync, active-high); keyLen/last_round/state_in/prev_key/key_in with the
// round_valid_in/round_ready_out handshake; state_out with the round_valid_out/round_ready_in handshake.
module decrypt_single_round #(
  parameter int KEY_WIDTH  = 128,
  parameter int DATA_WIDTH = 128,
  parameter int ROM_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  keyLen,
  input  logic                  last_round,
  input  logic                  round_valid_in,
  output logic                  round_ready_out,
  input  logic [DATA_WIDTH-1:0] state_in,
  input  logic [KEY_WIDTH-1:0]  prev_key,
  input  logic [KEY_WIDTH-1:0]  key_in,
  input  logic                  round_ready_in,
  output logic [DATA_WIDTH-1:0] state_out,
  output logic                  round_valid_out
);

  // The ROM word must at least hold one S-box byte.
  if (ROM_WIDTH < 8) begin : g_rom_width_check
    $error("ROM_WIDTH must be at least 8");
  end

  // Inverse S-box, entry 0x00 in the top byte, entry 0xFF in the bottom byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; row 0 is the top byte of the column word.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic         r_s1_valid;
  logic [127:0] r_s1_data;
  logic         r_valid_out;
  logic [127:0] r_state_out;

  logic         w_stall;
  logic [127:0] w_key_sel;
  logic [127:0] w_ark;
  logic [127:0] w_imc;
  logic [127:0] w_s1_next;
  logic [127:0] w_isr;
  logic [127:0] w_s2_next;

  assign w_stall         = r_valid_out & ~round_ready_in;
  assign round_ready_out = ~w_stall;
  assign round_valid_out = r_valid_out;
  assign state_out       = r_state_out;

  // Stage 1 combinational: key add then optional InvMixColumns.
  assign w_key_sel = keyLen ? prev_key[127:0] : key_in[127:0];
  assign w_ark     = state_in ^ w_key_sel;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
  end

  assign w_s1_next = last_round ? w_ark : w_imc;

  // Stage 2 combinational: byte k sits at row k%4, column k/4; row r rotates right by r.
  for (genvar c = 0; c < 4; c++) begin : g_isr_col
    for (genvar r = 0; r < 4; r++) begin : g_isr_row
      assign w_isr[127-8*(r+4*c) -: 8] = r_s1_data[127-8*(r+4*((c-r+4)%4)) -: 8];
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_isb
    assign w_s2_next[127-8*k -: 8] = inv_sbox(w_isr[127-8*k -: 8]);
  end

  // Both stages advance together; data registers load even for bubbles since only valid qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_valid_out <= 1'b0;
      r_state_out <= '0;
    end else if (!w_stall) begin
      r_s1_valid  <= round_valid_in;
      r_s1_data   <= w_s1_next;
      r_valid_out <= r_s1_valid;
      r_state_out <= w_s2_next;
    end
  end

endmodule

// File: tb/tb_decrypt_single_round.sv
module tb_decrypt_single_round;

  logic         clk = 1'b0;
  logic         rst;
  logic         keyLen;
  logic         last_round;
  logic         round_valid_in;
  logic         round_ready_out;
  logic [127:0] state_in;
  logic [127:0] prev_key;
  logic [127:0] key_in;
  logic         round_ready_in;
  logic [127:0] state_out;
  logic         round_valid_out;

  always #5 clk = ~clk;

  decrypt_single_round #(.KEY_WIDTH(128), .DATA_WIDTH(128), .ROM_WIDTH(20)) dut (
    .clk             (clk),
    .rst             (rst),
    .keyLen          (keyLen),
    .last_round      (last_round),
    .round_valid_in  (round_valid_in),
    .round_ready_out (round_ready_out),
    .state_in        (state_in),
    .prev_key        (prev_key),
    .key_in          (key_in),
    .round_ready_in  (round_ready_in),
    .state_out       (state_out),
    .round_valid_out (round_valid_out)
  );

  int           checks = 0;
  int           errors = 0;
  int           n_out  = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sb[256];

  // ---------------- reference model: forward AES round from GF(2^8) definitions ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] enc_round(input logic [127:0] p, input logic [127:0] key,
                                             input logic fin);
    logic [7:0]   a[16];
    logic [7:0]   s[16];
    logic [7:0]   m[16];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) a[k] = sb[p[127-8*k -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        s[rr+4*c] = a[rr + 4*((c+rr)%4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c+0] = gmul(8'h02, s[4*c]) ^ gmul(8'h03, s[4*c+1]) ^ s[4*c+2] ^ s[4*c+3];
      m[4*c+1] = s[4*c] ^ gmul(8'h02, s[4*c+1]) ^ gmul(8'h03, s[4*c+2]) ^ s[4*c+3];
      m[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(8'h02, s[4*c+2]) ^ gmul(8'h03, s[4*c+3]);
      m[4*c+3] = gmul(8'h03, s[4*c]) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(8'h02, s[4*c+3]);
    end
    for (int k = 0; k < 16; k++)
      r[127-8*k -: 8] = (fin ? s[k] : m[k]) ^ key[127-8*k -: 8];
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready, record handshakes, advance to the next edge + 1.
  task automatic cyc_step(input logic vin, input logic [127:0] st, input logic [127:0] kin,
                          input logic [127:0] pk, input logic kl, input logic lr, input logic rin,
                          input logic [127:0] exp, output logic acc);
    logic exp_rdy;
    round_valid_in = vin;
    state_in       = st;
    key_in         = kin;
    prev_key       = pk;
    keyLen         = kl;
    last_round     = lr;
    round_ready_in = rin;
    #1;
    exp_rdy = !(round_valid_out && !rin);
    chk("ready_out", round_ready_out, exp_rdy);
    if (round_valid_out && rin) begin
      n_out++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL out_unexpected observed=%h expected=none", state_out);
      end
      if (exp_q.size() > 0) chk("out_data", state_out, exp_q.pop_front());
    end
    acc = vin && round_ready_out;
    if (acc) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rin);
    logic acc;
    cyc_step(1'b0, '0, '0, '0, 1'b0, 1'b0, rin, '0, acc);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    chk({tag, "_drained"}, 128'(exp_q.size()), '0);
  endtask

  // Single beat into an empty pipeline: exact 2-cycle latency and data.
  task automatic directed(input string tag, input logic [127:0] st, input logic [127:0] kin,
                          input logic [127:0] pk, input logic kl, input logic lr,
                          input logic [127:0] exp);
    logic acc;
    cyc_step(1'b1, st, kin, pk, kl, lr, 1'b1, exp, acc);
    chk({tag, "_acc"}, 128'(acc), 128'(1));
    chk({tag, "_lat1"}, 128'(round_valid_out), '0);
    idle(1'b1);
    chk({tag, "_vld"}, 128'(round_valid_out), 128'(1));
    chk({tag, "_dat"}, state_out, exp);
    idle(1'b1);
    chk({tag, "_done"}, 128'(exp_q.size()), '0);
  endtask

  task automatic rand_beat(input int lr_mode, output logic [127:0] st, output logic [127:0] kin,
                           output logic [127:0] pk, output logic kl, output logic lr,
                           output logic [127:0] exp);
    logic [127:0] p;
    p   = {$urandom, $urandom, $urandom, $urandom};
    kin = {$urandom, $urandom, $urandom, $urandom};
    pk  = {$urandom, $urandom, $urandom, $urandom};
    kl  = 1'($urandom_range(0, 1));
    lr  = (lr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(lr_mode);
    st  = enc_round(p, kl ? pk : kin, lr);
    exp = p;
  endtask

  initial begin
    logic [127:0] st, kin, pk, ex;
    logic         kl, lr, acc, rin;
    int           sent, lows, n0;

    build_sbox();
    rst = 1'b1;
    round_valid_in = 1'b0;
    round_ready_in = 1'b1;
    keyLen = 1'b0;
    last_round = 1'b0;
    state_in = '0;
    key_in = '0;
    prev_key = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid_out", 128'(round_valid_out), '0);
    chk("rst_state_out", state_out, '0);
    chk("rst_ready_out", 128'(round_ready_out), 128'(1));

    // Directed vectors
    directed("identity", {16{8'h63}}, '0, '0, 1'b0, 1'b0, '0);
    directed("keysel_prev", '0, {16{8'hff}}, {16{8'h63}}, 1'b1, 1'b0, '0);
    directed("keysel_in", '0, {16{8'hff}}, {16{8'h63}}, 1'b0, 1'b0, {16{8'h7d}});
    directed("last_round", 128'h637c777bf26b6fc53001672bfed7ab76, '0, '0, 1'b0, 1'b1,
             128'h000d0a0704010e0b0805020f0c090603);

    // Round-trip, normal rounds then final rounds, streamed back to back
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 100; i++) begin
        rand_beat(mode, st, kin, pk, kl, lr, ex);
        cyc_step(1'b1, st, kin, pk, kl, lr, 1'b1, ex, acc);
        if (!acc) chk("stream_acc", 128'(acc), 128'(1));
      end
      drain(mode == 0 ? "rt_normal" : "rt_final");
    end

    // Backpressure: 8 beats, ready_in low for at most 5 consecutive cycles
    sent = 0;
    lows = 0;
    n0 = n_out;
    rand_beat(2, st, kin, pk, kl, lr, ex);
    for (int c = 0; c < 300 && (sent < 8 || exp_q.size() > 0); c++) begin
      rin = (lows >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      lows = rin ? 0 : lows + 1;
      cyc_step(sent < 8, st, kin, pk, kl, lr, rin, ex, acc);
      if (acc) begin
        sent++;
        rand_beat(2, st, kin, pk, kl, lr, ex);
      end
    end
    chk("bp_sent", 128'(sent), 128'(8));
    chk("bp_delivered", 128'(n_out - n0), 128'(8));
    chk("bp_left", 128'(exp_q.size()), '0);

    // Reset with two beats in flight
    rand_beat(0, st, kin, pk, kl, lr, ex);
    cyc_step(1'b1, st, kin, pk, kl, lr, 1'b1, ex, acc);
    rand_beat(1, st, kin, pk, kl, lr, ex);
    cyc_step(1'b1, st, kin, pk, kl, lr, 1'b0, ex, acc);
    chk("mid_inflight", 128'(round_valid_out), 128'(1));
    rst = 1'b1;
    round_valid_in = 1'b0;
    round_ready_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 128'(round_valid_out), '0);
    chk("mid_rst_state", state_out, '0);
    chk("mid_rst_ready", 128'(round_ready_out), 128'(1));
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("post_rst_quiet", 128'(round_valid_out), '0);
    end
    rand_beat(2, st, kin, pk, kl, lr, ex);
    directed("post_rst", st, kin, pk, kl, lr, ex);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
